// File: rtl/t06_grid_spi_scanner.sv
// -----------------------------------------------------------------------------
// t06_grid_spi_scanner
//
// Reader side of the game's pixel-query interface. On each accepted
// frame_start the block walks the GRID_W x GRID_H play grid in row-major order
// (x fastest). For each cell it drives x/y, samples the returned flags and
// converts them to an RGB565 colour. It streams one RAMWR command byte followed
// by one 16-bit pixel per cell over a write-only SPI link (mode 0, MSB first).
//
// Optional feature macro: GAMEOVER_TINT_EN
//   When defined, background cells (no flag set) are sent as 16'h8000 while
//   gameover_in is high in the sample cycle. When undefined, gameover_in is
//   unused and background is always 16'h0000.
//
// Ports
//   clk          in   1  system clock, all logic on posedge
//   nrst         in   1  synchronous active-low reset
//   frame_start  in   1  one-cycle frame request, ignored while busy
//   apple_in     in   1  queried cell holds an apple
//   wall_in      in   1  queried cell is wall
//   body_in      in   1  queried cell is snake body
//   head_in      in   1  queried cell is snake head
//   gameover_in  in   1  game-over flag (tint feature only)
//   x_out        out  4  queried column
//   y_out        out  4  queried row
//   spi_sclk     out  1  SPI clock, idle low
//   spi_mosi     out  1  SPI data, MSB first
//   spi_cs_n     out  1  chip select, active low
//   spi_dc       out  1  0 = command byte, 1 = pixel data
//   busy         out  1  frame in progress
//   frame_done   out  1  one-cycle pulse at end of frame
// -----------------------------------------------------------------------------
module t06_grid_spi_scanner #(
    parameter int          GRID_W    = 16,
    parameter int          GRID_H    = 16,
    parameter int          SCLK_DIV  = 2,
    parameter logic [7:0]  RAMWR_CMD = 8'h2C
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       frame_start,
    input  logic       apple_in,
    input  logic       wall_in,
    input  logic       body_in,
    input  logic       head_in,
    input  logic       gameover_in,
    output logic [3:0] x_out,
    output logic [3:0] y_out,
    output logic       spi_sclk,
    output logic       spi_mosi,
    output logic       spi_cs_n,
    output logic       spi_dc,
    output logic       busy,
    output logic       frame_done
);

    localparam int               DIV_W    = $clog2(2 * SCLK_DIV + 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SCLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SCLK_DIV - 1);
    localparam logic [3:0]       X_LAST   = 4'(GRID_W - 1);
    localparam logic [3:0]       Y_LAST   = 4'(GRID_H - 1);

    // SETUP and HOLD are the one-cycle chip-select setup/hold slots that
    // bracket the serial stream with sclk low.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_FETCH,
        ST_SAMPLE,
        ST_SHIFT,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t           state;
    logic [15:0]      shreg;
    logic [3:0]       bit_cnt;
    logic [DIV_W-1:0] div_cnt;
    logic [15:0]      bg_colour;

    // Priority encode the cell flags into an RGB565 colour.
    function automatic logic [15:0] cell_colour(
        input logic        head,
        input logic        body,
        input logic        apple,
        input logic        wall,
        input logic [15:0] bg
    );
        logic [15:0] c;
        if (head) begin
            c = 16'h07E0;
        end else if (body) begin
            c = 16'h03E0;
        end else if (apple) begin
            c = 16'hF800;
        end else if (wall) begin
            c = 16'hFFFF;
        end else begin
            c = bg;
        end
        return c;
    endfunction

`ifdef GAMEOVER_TINT_EN
    // Background colour follows the game-over flag.
    assign bg_colour = gameover_in ? 16'h8000 : 16'h0000;
`else
    logic unused_gameover;
    // Game-over flag has no effect in this build.
    assign unused_gameover = gameover_in;
    assign bg_colour       = 16'h0000;
`endif

    // Frame sequencer: grid walk, SPI bit timing and all registered outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state      <= ST_IDLE;
            shreg      <= 16'h0000;
            bit_cnt    <= 4'd0;
            div_cnt    <= '0;
            x_out      <= 4'd0;
            y_out      <= 4'd0;
            spi_sclk   <= 1'b0;
            spi_mosi   <= 1'b0;
            spi_cs_n   <= 1'b1;
            spi_dc     <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (frame_start) begin
                        state    <= ST_SETUP;
                        shreg    <= {RAMWR_CMD, 8'h00};
                        x_out    <= 4'd0;
                        y_out    <= 4'd0;
                        spi_cs_n <= 1'b0;
                        spi_dc   <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ST_SETUP: begin
                    // First command bit is presented with sclk low.
                    spi_mosi <= shreg[15];
                    shreg    <= {shreg[14:0], 1'b0};
                    bit_cnt  <= 4'd0;
                    div_cnt  <= '0;
                    state    <= ST_CMD;
                end
                ST_CMD, ST_SHIFT: begin
                    // div_cnt 0..D-1 is the low phase, D..2D-1 the high phase.
                    if (div_cnt == DIV_HALF) begin
                        spi_sclk <= 1'b1;
                    end
                    if (div_cnt == DIV_LAST) begin
                        div_cnt  <= '0;
                        spi_sclk <= 1'b0;
                        if (bit_cnt == ((state == ST_CMD) ? 4'd7 : 4'd15)) begin
                            bit_cnt <= 4'd0;
                            if (state == ST_CMD) begin
                                spi_dc <= 1'b1;
                                x_out  <= 4'd0;
                                y_out  <= 4'd0;
                                state  <= ST_FETCH;
                            end else if ((x_out == X_LAST) && (y_out == Y_LAST)) begin
                                state <= ST_HOLD;
                            end else begin
                                if (x_out == X_LAST) begin
                                    x_out <= 4'd0;
                                    y_out <= y_out + 4'd1;
                                end else begin
                                    x_out <= x_out + 4'd1;
                                end
                                state <= ST_FETCH;
                            end
                        end else begin
                            // Next bit changes mosi on the falling sclk.
                            spi_mosi <= shreg[15];
                            shreg    <= {shreg[14:0], 1'b0};
                            bit_cnt  <= bit_cnt + 4'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + {{(DIV_W-1){1'b0}}, 1'b1};
                    end
                end
                ST_FETCH: begin
                    // x/y are already on the bus; give the flags a cycle to settle.
                    state <= ST_SAMPLE;
                end
                ST_SAMPLE: begin
                    spi_mosi <= cell_colour(head_in, body_in, apple_in, wall_in, bg_colour) >> 15;
                    shreg    <= cell_colour(head_in, body_in, apple_in, wall_in, bg_colour) << 1;
                    bit_cnt  <= 4'd0;
                    div_cnt  <= '0;
                    state    <= ST_SHIFT;
                end
                ST_HOLD: begin
                    spi_cs_n   <= 1'b1;
                    spi_dc     <= 1'b0;
                    spi_mosi   <= 1'b0;
                    spi_sclk   <= 1'b0;
                    busy       <= 1'b0;
                    frame_done <= 1'b1;
                    state      <= ST_DONE;
                end
                ST_DONE: begin
                    // frame_start is deliberately ignored here.
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_t06_grid_spi_scanner.sv
// -----------------------------------------------------------------------------
// tb_t06_grid_spi_scanner
//
// Self-checking bench for t06_grid_spi_scanner. A grid model answers the
// x/y pixel queries, a monitor decodes the SPI stream on every sclk rise and
// compares the command byte, the queried coordinates and every pixel word
// against values predicted from the colour rules. Frame timing, dropped
// frame_start requests and mid-frame reset are checked directly.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_t06_grid_spi_scanner;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       frame_start = 1'b0;
    logic       apple_in, wall_in, body_in, head_in, gameover_in;
    logic [3:0] x_out, y_out;
    logic       spi_sclk, spi_mosi, spi_cs_n, spi_dc, busy, frame_done;

    int checks = 0;
    int errors = 0;
    int scen   = 0;

    // monitor state
    int          cyc = 0;
    logic        mon_clear = 1'b0;
    logic        prev_sclk = 1'b0;
    logic        prev_busy = 1'b0;
    logic [7:0]  cmd_sr = 8'h00;
    int          cmd_bits = 0;
    logic [15:0] pix_sr = 16'h0000;
    int          pix_bits = 0;
    int          pix_n = 0;
    int          done_cnt = 0;
    int          rise_cyc = 0;
    int          done_cyc = 0;
    logic [15:0] exp_pix [256];
    logic [15:0] got     [256];

    t06_grid_spi_scanner dut (
        .clk         (clk),
        .nrst        (nrst),
        .frame_start (frame_start),
        .apple_in    (apple_in),
        .wall_in     (wall_in),
        .body_in     (body_in),
        .head_in     (head_in),
        .gameover_in (gameover_in),
        .x_out       (x_out),
        .y_out       (y_out),
        .spi_sclk    (spi_sclk),
        .spi_mosi    (spi_mosi),
        .spi_cs_n    (spi_cs_n),
        .spi_dc      (spi_dc),
        .busy        (busy),
        .frame_done  (frame_done)
    );

    always #5 clk = ~clk;

    // Grid contents per scenario: returns {head, body, apple, wall}.
    function automatic logic [3:0] flags_of(input int s, input int x, input int y);
        logic [3:0] f;
        f = 4'b0000;
        if (s == 1) begin
            if (x == 3 && y == 2) f[3] = 1'b1;
            if (x == 4 && y == 2) f[2] = 1'b1;
            if (x == 9 && y == 9) f[1] = 1'b1;
            if (y == 0)           f[0] = 1'b1;
        end else if (s == 2) begin
            if (x == 0 && y == 0) f = 4'b1111;
        end
        return f;
    endfunction

    // Expected RGB565 of a cell from the display rules.
    function automatic logic [15:0] model_colour(input int s, input int x, input int y);
        logic [3:0]  f;
        logic [15:0] c;
        f = flags_of(s, x, y);
`ifdef GAMEOVER_TINT_EN
        c = (s == 2) ? 16'h8000 : 16'h0000;
`else
        c = 16'h0000;
`endif
        if (f[0]) c = 16'hFFFF;
        if (f[1]) c = 16'hF800;
        if (f[2]) c = 16'h03E0;
        if (f[3]) c = 16'h07E0;
        return c;
    endfunction

    // Game model responds combinationally to the queried coordinates.
    always_comb begin
        {head_in, body_in, apple_in, wall_in} = flags_of(scen, int'(x_out), int'(y_out));
        gameover_in = (scen == 2);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // SPI decoder and frame monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (mon_clear) begin
            cmd_bits = 0; pix_bits = 0; pix_n = 0;
            done_cnt = 0; rise_cyc = 0; done_cyc = 0;
        end else begin
            if (busy && !prev_busy) rise_cyc = cyc;
            if (frame_done) begin
                done_cnt = done_cnt + 1;
                done_cyc = cyc;
            end
            if (spi_sclk && !prev_sclk) begin
                chk("cs_low_at_sclk_rise", 32'(spi_cs_n), 32'd0);
                if (!spi_dc) begin
                    cmd_sr   = {cmd_sr[6:0], spi_mosi};
                    cmd_bits = cmd_bits + 1;
                    if (cmd_bits == 8) chk("ramwr_byte", 32'(cmd_sr), 32'h2C);
                end else if (pix_n < 256) begin
                    chk($sformatf("x_out_px%0d", pix_n), 32'(x_out), 32'(pix_n % 16));
                    chk($sformatf("y_out_px%0d", pix_n), 32'(y_out), 32'(pix_n / 16));
                    pix_sr   = {pix_sr[14:0], spi_mosi};
                    pix_bits = pix_bits + 1;
                    if (pix_bits == 16) begin
                        pix_bits   = 0;
                        got[pix_n] = pix_sr;
                        chk($sformatf("pixel%0d", pix_n), 32'(pix_sr), 32'(exp_pix[pix_n]));
                        pix_n = pix_n + 1;
                    end
                end else begin
                    chk("extra_pixel_bits", 32'(pix_n), 32'd255);
                end
            end
        end
        prev_sclk = spi_sclk;
        prev_busy = busy;
    end

    // Render one frame with scenario s; optionally re-pulse frame_start while busy.
    task automatic run_frame(input int s, input bit repulse);
        int k;
        bit got_done;
        scen = s;
        for (int i = 0; i < 256; i++) exp_pix[i] = model_colour(s, i % 16, i / 16);
        mon_clear = 1'b1;
        @(negedge clk);
        mon_clear   = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        k = 1;
        got_done = 1'b0;
        while (!got_done && k < 20000) begin
            frame_start = repulse && (k == 100);
            @(negedge clk);
            k++;
            if (frame_done) got_done = 1'b1;
        end
        frame_start = 1'b0;
        chk("frame_done_seen", 32'(got_done), 32'd1);
        if (repulse) begin
            // request lands in the DONE cycle and must be dropped
            frame_start = 1'b1;
            @(negedge clk);
            frame_start = 1'b0;
        end
        repeat (40) @(negedge clk);
        chk("cmd_bit_count", 32'(cmd_bits), 32'd8);
        chk("pixel_count", 32'(pix_n), 32'd256);
        chk("busy_to_done_cycles", 32'(done_cyc - rise_cyc), 32'd16930);
        chk("single_frame_done", 32'(done_cnt), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_cs_n", 32'(spi_cs_n), 32'd1);
    endtask

    initial begin
        int w;
        // reset state
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_x", 32'(x_out), 32'd0);
        chk("rst_y", 32'(y_out), 32'd0);
        chk("rst_sclk", 32'(spi_sclk), 32'd0);
        chk("rst_mosi", 32'(spi_mosi), 32'd0);
        chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
        chk("rst_dc", 32'(spi_dc), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        nrst = 1'b1;
        repeat (2) @(negedge clk);

        // blank frame with frame_start re-pulsed at cycle 100 and in the DONE cycle
        run_frame(0, 1'b1);
        chk("blank_px0", 32'(got[0]), 32'h0000);
        chk("blank_px255", 32'(got[255]), 32'h0000);

        // abort during pixel 40
        scen = 0;
        for (int i = 0; i < 256; i++) exp_pix[i] = model_colour(0, i % 16, i / 16);
        mon_clear = 1'b1;
        @(negedge clk);
        mon_clear   = 1'b0;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        w = 0;
        while (pix_n < 40 && w < 5000) begin
            @(negedge clk);
            w++;
        end
        chk("reached_pixel40", 32'(pix_n), 32'd40);
        repeat (7) @(negedge clk);
        nrst = 1'b0;
        @(negedge clk);
        chk("abort_cs_n", 32'(spi_cs_n), 32'd1);
        chk("abort_sclk", 32'(spi_sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_x", 32'(x_out), 32'd0);
        nrst = 1'b1;
        repeat (200) @(negedge clk);
        chk("abort_no_frame_done", 32'(done_cnt), 32'd0);

        // restart with the sprite layout: row-0 wall, head, body, apple
        run_frame(1, 1'b0);
        for (int i = 0; i < 16; i++) chk($sformatf("wall_px%0d", i), 32'(got[i]), 32'hFFFF);
        chk("head_px35", 32'(got[35]), 32'h07E0);
        chk("body_px36", 32'(got[36]), 32'h03E0);
        chk("apple_px153", 32'(got[153]), 32'hF800);
        chk("bg_px34", 32'(got[34]), 32'h0000);

        // all flags at (0,0) plus game-over asserted
        run_frame(2, 1'b0);
        chk("prio_px0", 32'(got[0]), 32'h07E0);
`ifdef GAMEOVER_TINT_EN
        chk("tint_px1", 32'(got[1]), 32'h8000);
`else
        chk("notint_px1", 32'(got[1]), 32'h0000);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
